// File: rtl/spi_led_matrix_receiver.sv
// SPI mode-0 slave for the LED-matrix link: oversamples SCLK/MOSI/N_CS, assembles
// MSB-first bytes, handles the frame-index-reset command and fills a 64-pixel RGB332 buffer.
module spi_led_matrix_receiver (
  input  logic       clock,
  input  logic       reset_async,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       n_cs,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_pixel,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       pixel_we,
  output logic [5:0] pixel_addr,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       partial_err
);

  localparam logic [7:0] CMD_RESET_FRAME_INDEX = 8'h26;
  localparam int         NUM_PIXELS            = 64;
  localparam logic [5:0] LAST_ADDR             = 6'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, FIRST, DATA} state_t;

  logic [1:0] rst_chain;
  logic       rst;

  // Assert immediately, release two clock edges after reset_async drops.
  always_ff @(posedge clock or posedge reset_async) begin
    if (reset_async) rst_chain <= 2'b11;
    else             rst_chain <= {rst_chain[0], 1'b0};
  end
  assign rst = rst_chain[1];

  // [0],[1] synchroniser, [2] history; mosi is only sampled, so it needs no history flop.
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], n_cs};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  logic sclk_rise, cs_fall, cs_rise;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];

  state_t     state, state_next;
  logic [2:0] bit_cnt, bits_pending;
  logic [7:0] shift, byte_val;
  logic       active, byte_done, is_cmd, do_write, do_partial;

  assign active       = (state != IDLE);
  assign byte_val     = {shift[6:0], mosi_s[1]};
  assign byte_done    = active && sclk_rise && (bit_cnt == 3'd7);
  assign bits_pending = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = FIRST;
      FIRST:   if (cs_rise) state_next = IDLE;
               else if (byte_done) state_next = DATA;
      DATA:    if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A byte completing on the same cycle as the N_CS rise is still dispatched.
  always_comb begin
    is_cmd     = 1'b0;
    do_write   = 1'b0;
    do_partial = 1'b0;
    if (byte_done) begin
      if (state == FIRST && byte_val == CMD_RESET_FRAME_INDEX) is_cmd = 1'b1;
      else do_write = 1'b1;
    end
    if (active && cs_rise && bits_pending != 3'd0) do_partial = 1'b1;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if (!active || cs_rise) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= byte_val;
    end
  end

  logic [7:0] buffer [NUM_PIXELS];
  logic [5:0] index;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_byte     <= 8'h00;
      pixel_we    <= 1'b0;
      pixel_addr  <= 6'd0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
      partial_err <= 1'b0;
      index       <= 6'd0;
      rd_pixel    <= 8'h00;
      for (int i = 0; i < NUM_PIXELS; i++) buffer[i] <= 8'h00;
    end else begin
      rx_valid    <= byte_done;
      pixel_we    <= do_write;
      frame_done  <= do_write && (index == LAST_ADDR);
      partial_err <= do_partial;
      rd_pixel    <= buffer[rd_addr];
      if (byte_done) rx_byte <= byte_val;
      if (is_cmd) index <= 6'd0;
      if (do_write) begin
        buffer[index] <= byte_val;
        pixel_addr    <= index;
        index         <= index + 6'd1;
        if (index == LAST_ADDR) frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_led_matrix_receiver.sv
// Bench for spi_led_matrix_receiver: bit-banged SPI at clock/4, scoreboard of expected
// bytes / pixel addresses / frame counts compared as the receiver pulses its outputs.
module tb_spi_led_matrix_receiver;

  logic       clock = 1'b0;
  logic       reset_async;
  logic       sclk, mosi, n_cs;
  logic [5:0] rd_addr;
  logic [7:0] rd_pixel, rx_byte, frame_count;
  logic       rx_valid, pixel_we, frame_done, partial_err;
  logic [5:0] pixel_addr;

  spi_led_matrix_receiver dut (
    .clock(clock), .reset_async(reset_async), .sclk(sclk), .mosi(mosi), .n_cs(n_cs),
    .rd_addr(rd_addr), .rd_pixel(rd_pixel), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .pixel_we(pixel_we), .pixel_addr(pixel_addr), .frame_done(frame_done),
    .frame_count(frame_count), .partial_err(partial_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  logic [7:0] rx_q[$];
  logic [5:0] px_q[$];
  logic [7:0] fc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_buf [64];
  logic [5:0] exp_idx;
  logic [7:0] exp_frames;
  int         rx_seen, partial_seen;

  // Scoreboard side: pop and compare whenever the receiver pulses an output.
  always @(negedge clock) begin
    if (!reset_async) begin
      if (rx_valid) begin
        rx_seen++;
        checks++;
        if (rx_q.size() == 0) $display("FAIL rx_byte: unexpected rx_valid with %h", rx_byte);
        else begin
          logic [7:0] e;
          e = rx_q.pop_front();
          if (rx_byte !== e) $display("FAIL rx_byte: got %h expected %h", rx_byte, e);
          else passed++;
        end
      end
      if (pixel_we) begin
        checks++;
        if (px_q.size() == 0) $display("FAIL pixel_addr: unexpected pixel_we at %0d", pixel_addr);
        else begin
          logic [5:0] e;
          e = px_q.pop_front();
          if (pixel_addr !== e) $display("FAIL pixel_addr: got %0d expected %0d", pixel_addr, e);
          else passed++;
        end
      end
      if (frame_done) begin
        checks++;
        if (fc_q.size() == 0) $display("FAIL frame_done: unexpected pulse, frame_count %0d", frame_count);
        else begin
          logic [7:0] e;
          e = fc_q.pop_front();
          if (frame_count !== e || pixel_we !== 1'b1)
            $display("FAIL frame_done: frame_count %0d pixel_we %b expected %0d and 1", frame_count, pixel_we, e);
          else passed++;
        end
      end
      if (partial_err) partial_seen++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    rx_q.delete(); px_q.delete(); fc_q.delete();
    for (int i = 0; i < 64; i++) exp_buf[i] = 8'h00;
    exp_idx = 6'd0; exp_frames = 8'd0; rx_seen = 0; partial_seen = 0;
  endtask

  task automatic spi_bit(input logic b);
    sclk = 1'b0; mosi = b;
    repeat (2) @(negedge clock);
    sclk = 1'b1;
    repeat (2) @(negedge clock);
    sclk = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clock); n_cs = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic cs_end();
    repeat (3) @(negedge clock); n_cs = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Sends tx_q as one transaction, pushing the expected outcome of each byte first.
  task automatic run_txn();
    for (int n = 0; n < tx_q.size(); n++) begin
      logic [7:0] b;
      b = tx_q[n];
      if (n == 0) cs_begin();
      rx_q.push_back(b);
      if (n == 0 && b == 8'h26) exp_idx = 6'd0;
      else begin
        px_q.push_back(exp_idx);
        exp_buf[exp_idx] = b;
        if (exp_idx == 6'd63) begin
          exp_frames = exp_frames + 8'd1;
          fc_q.push_back(exp_frames);
        end
        exp_idx = exp_idx + 6'd1;
      end
      for (int k = 7; k >= 0; k--) spi_bit(b[k]);
    end
    cs_end();
    tx_q.delete();
  endtask

  task automatic test_readback();
    for (int a = 0; a < 64; a++) begin
      @(negedge clock); rd_addr = 6'(a);
      @(negedge clock);
      checks++;
      if (rd_pixel !== exp_buf[a]) $display("FAIL readback[%0d]: got %h expected %h", a, rd_pixel, exp_buf[a]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    cs_begin();
    for (int k = 0; k < 3; k++) spi_bit(1'b1);
    @(negedge clock); reset_async = 1'b1;
    #1;
    checks++;
    if ({rx_valid, rx_byte, pixel_we, pixel_addr, frame_done, frame_count, partial_err, rd_pixel} !== '0)
      $display("FAIL reset_outputs: rx_byte %h pixel_addr %0d frame_count %0d rd_pixel %h (all 0 required)",
               rx_byte, pixel_addr, frame_count, rd_pixel);
    else passed++;
    n_cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clock);
    reset_async = 1'b0;
    model_clear();
    repeat (4) @(negedge clock);
    test_readback();
  endtask

  task automatic test_cmd_frame();
    tx_q.push_back(8'h26);
    run_txn();
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
    run_txn();
    checks++;
    if (frame_count !== 8'd1 || px_q.size() != 0 || fc_q.size() != 0)
      $display("FAIL cmd_frame: frame_count %0d pending px %0d fd %0d, expected 1/0/0", frame_count, px_q.size(), fc_q.size());
    else passed++;
    for (int a = 0; a < 64; a++) begin
      @(negedge clock); rd_addr = 6'(a);
      @(negedge clock);
      checks++;
      if (rd_pixel !== 8'(a)) $display("FAIL cmd_frame_pixel[%0d]: got %h expected %h", a, rd_pixel, 8'(a));
      else passed++;
    end
  endtask

  task automatic test_cmd_only_first();
    int rx0;
    rx0 = rx_seen;
    tx_q.push_back(8'h26); tx_q.push_back(8'h26); tx_q.push_back(8'hE0);
    run_txn();
    checks++;
    if (rx_seen - rx0 != 3 || exp_idx != 6'd2 || rx_q.size() != 0)
      $display("FAIL cmd_only_first: rx_valid pulses %0d expected 3", rx_seen - rx0);
    else passed++;
    test_readback();
  endtask

  task automatic test_partial();
    int rx0;
    int p0;
    rx0 = rx_seen; p0 = partial_seen;
    cs_begin();
    for (int k = 0; k < 5; k++) spi_bit(k[0]);
    cs_end();
    checks++;
    if (partial_seen - p0 != 1 || rx_seen != rx0)
      $display("FAIL partial_err: pulses %0d rx_valid %0d expected 1 and 0", partial_seen - p0, rx_seen - rx0);
    else passed++;
    tx_q.push_back(8'hA5);
    run_txn();
    checks++;
    if (px_q.size() != 0 || partial_seen - p0 != 1)
      $display("FAIL partial_followup: pending px %0d partial pulses %0d", px_q.size(), partial_seen - p0);
    else passed++;
    test_readback();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 66; i++) tx_q.push_back(8'h80 + 8'(i));
    run_txn();
    checks++;
    if (frame_count !== 8'd1 || fc_q.size() != 0 || px_q.size() != 0)
      $display("FAIL wrap: frame_count %0d expected 1, pending fd %0d px %0d", frame_count, fc_q.size(), px_q.size());
    else passed++;
    test_readback();
  endtask

  task automatic test_loopback();
    for (int f = 1; f <= 3; f++) begin
      tx_q.push_back(8'h26);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          tx_q.push_back((r + c == f - 1) ? 8'hFF : 8'h00);
      run_txn();
    end
    checks++;
    if (frame_count !== 8'd3 || partial_seen != 0)
      $display("FAIL loopback: frame_count %0d partial_err %0d, expected 3 and 0", frame_count, partial_seen);
    else passed++;
    for (int a = 0; a < 64; a++) begin
      logic [7:0] e;
      e = ((a / 8) + (a % 8) == 2) ? 8'hFF : 8'h00;
      @(negedge clock); rd_addr = 6'(a);
      @(negedge clock);
      checks++;
      if (rd_pixel !== e) $display("FAIL loopback_pixel[%0d]: got %h expected %h", a, rd_pixel, e);
      else passed++;
    end
  endtask

  initial begin
    reset_async = 1'b1; sclk = 1'b0; mosi = 1'b0; n_cs = 1'b1; rd_addr = 6'd0;
    model_clear();
    repeat (3) @(negedge clock);
    reset_async = 1'b0;
    repeat (4) @(negedge clock);
    test_reset();
    test_cmd_frame();
    test_cmd_only_first();
    test_partial();
    test_reset();
    test_wrap();
    test_reset();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
